// File: rtl/axil_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : AXIL_IF (interface)
//  Purpose  : AXI4-Lite bundle shared by the arbiter's requester and
//             downstream ports. The master modport drives AW/W/AR and the
//             B/R ready signals; the slave modport is the mirror image.
//  Params   : ADDR_WIDTH - address width
//             DATA_WIDTH - data width (STRB_WIDTH = DATA_WIDTH/8)
//  Revision : 1.0 - initial release
// ============================================================================
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axil_arbiter
//  Purpose  : Two-requester AXI4-Lite arbiter onto one downstream register
//             bus. Four request slots (S0W, S0R, S1W, S1R) are served
//             round-robin with a single transaction outstanding downstream.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous active-high reset
//             s0_axil_if - requester 0 (slave modport)
//             s1_axil_if - requester 1 (slave modport)
//             m_axil_if  - shared downstream bus (master modport)
//  Config   : AXIL_ARBITER_ADDR_CHECK_EN - when defined, granted addresses
//             outside (addr & ADDR_MASK) == ADDR_BASE are answered locally
//             with DECERR and never reach m_axil_if.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = '0
) (
  input logic    clk,
  input logic    reset,
  AXIL_IF.slave  s0_axil_if,
  AXIL_IF.slave  s1_axil_if,
  AXIL_IF.master m_axil_if
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_RESP      = 3'd4
  } state_t;

  state_t     r_state, w_state_next;
  logic [1:0] r_ptr;       // round-robin pointer (slot index)
  logic [1:0] r_grant;     // granted slot: bit1 = port, bit0 = read
  logic       r_aw_done;
  logic       r_w_done;

  logic [3:0] w_req;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_pick_vld;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_resp_done;
  logic       w_dec_err;

  // Granted requester's view (muxed in) and the responses going back to it.
  logic                  w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
  logic [ADDR_WIDTH-1:0] w_g_awaddr, w_g_araddr;
  logic [2:0]            w_g_awprot, w_g_arprot;
  logic [DATA_WIDTH-1:0] w_g_wdata;
  logic [STRB_WIDTH-1:0] w_g_wstrb;
  logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic [1:0]            w_bresp, w_rresp;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req = {s1_axil_if.arvalid, s1_axil_if.awvalid,
                  s0_axil_if.arvalid, s0_axil_if.awvalid};

  // First asserted slot at or after the pointer: scan the farthest offset
  // first so the nearest hit overwrites it.
  always_comb begin
    w_pick     = r_ptr;
    w_pick_vld = 1'b0;
    w_idx      = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (w_req[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

`ifdef AXIL_ARBITER_ADDR_CHECK_EN
  logic                  r_dec_err;
  logic [ADDR_WIDTH-1:0] w_pick_addr;

  always_comb begin
    case (w_pick)
      2'd0:    w_pick_addr = s0_axil_if.awaddr;
      2'd1:    w_pick_addr = s0_axil_if.araddr;
      2'd2:    w_pick_addr = s1_axil_if.awaddr;
      default: w_pick_addr = s1_axil_if.araddr;
    endcase
  end

  // Window decision is taken once at grant time and held for the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_err <= 1'b0;
    end else if (r_state == IDLE && w_pick_vld) begin
      r_dec_err <= (w_pick_addr & ADDR_MASK) != ADDR_BASE;
    end
  end

  assign w_dec_err = r_dec_err;
`else
  assign w_dec_err = 1'b0;
`endif

  // Mux the granted requester's request-side signals.
  always_comb begin
    if (r_grant[1]) begin
      w_g_awvalid = s1_axil_if.awvalid;
      w_g_awaddr  = s1_axil_if.awaddr;
      w_g_awprot  = s1_axil_if.awprot;
      w_g_wvalid  = s1_axil_if.wvalid;
      w_g_wdata   = s1_axil_if.wdata;
      w_g_wstrb   = s1_axil_if.wstrb;
      w_g_bready  = s1_axil_if.bready;
      w_g_arvalid = s1_axil_if.arvalid;
      w_g_araddr  = s1_axil_if.araddr;
      w_g_arprot  = s1_axil_if.arprot;
      w_g_rready  = s1_axil_if.rready;
    end else begin
      w_g_awvalid = s0_axil_if.awvalid;
      w_g_awaddr  = s0_axil_if.awaddr;
      w_g_awprot  = s0_axil_if.awprot;
      w_g_wvalid  = s0_axil_if.wvalid;
      w_g_wdata   = s0_axil_if.wdata;
      w_g_wstrb   = s0_axil_if.wstrb;
      w_g_bready  = s0_axil_if.bready;
      w_g_arvalid = s0_axil_if.arvalid;
      w_g_araddr  = s0_axil_if.araddr;
      w_g_arprot  = s0_axil_if.arprot;
      w_g_rready  = s0_axil_if.rready;
    end
  end

  // Next state and all outputs. Everything defaults to 0 so that idle,
  // reset and non-granted ports present a quiet bus.
  always_comb begin
    w_state_next        = r_state;
    w_aw_hs             = 1'b0;
    w_w_hs              = 1'b0;
    w_resp_done         = 1'b0;
    w_awready           = 1'b0;
    w_wready            = 1'b0;
    w_bvalid            = 1'b0;
    w_bresp             = 2'b00;
    w_arready           = 1'b0;
    w_rvalid            = 1'b0;
    w_rdata             = '0;
    w_rresp             = 2'b00;
    m_axil_if.awvalid   = 1'b0;
    m_axil_if.awaddr    = '0;
    m_axil_if.awprot    = 3'b000;
    m_axil_if.wvalid    = 1'b0;
    m_axil_if.wdata     = '0;
    m_axil_if.wstrb     = '0;
    m_axil_if.bready    = 1'b0;
    m_axil_if.arvalid   = 1'b0;
    m_axil_if.araddr    = '0;
    m_axil_if.arprot    = 3'b000;
    m_axil_if.rready    = 1'b0;

    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            w_state_next = w_pick[0] ? RD_ADDR : WR_ADDR_DATA;
          end
        end

        WR_ADDR_DATA: begin
          if (!w_dec_err) begin
            // A channel that already handshook is masked in both directions.
            m_axil_if.awvalid = w_g_awvalid & ~r_aw_done;
            m_axil_if.awaddr  = w_g_awaddr;
            m_axil_if.awprot  = w_g_awprot;
            m_axil_if.wvalid  = w_g_wvalid & ~r_w_done;
            m_axil_if.wdata   = w_g_wdata;
            m_axil_if.wstrb   = w_g_wstrb;
            w_awready         = m_axil_if.awready & ~r_aw_done;
            w_wready          = m_axil_if.wready & ~r_w_done;
          end else begin
            w_awready = ~r_aw_done;
            w_wready  = ~r_w_done;
          end
          w_aw_hs = w_g_awvalid & w_awready;
          w_w_hs  = w_g_wvalid & w_wready;
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
            w_state_next = WR_RESP;
          end
        end

        WR_RESP: begin
          if (!w_dec_err) begin
            w_bvalid         = m_axil_if.bvalid;
            w_bresp          = m_axil_if.bresp;
            m_axil_if.bready = w_g_bready;
          end else begin
            w_bvalid = 1'b1;
            w_bresp  = 2'b11;
          end
          if (w_bvalid && w_g_bready) begin
            w_resp_done  = 1'b1;
            w_state_next = IDLE;
          end
        end

        RD_ADDR: begin
          if (!w_dec_err) begin
            m_axil_if.arvalid = w_g_arvalid;
            m_axil_if.araddr  = w_g_araddr;
            m_axil_if.arprot  = w_g_arprot;
            w_arready         = m_axil_if.arready;
          end else begin
            w_arready = 1'b1;
          end
          if (w_g_arvalid && w_arready) begin
            w_state_next = RD_RESP;
          end
        end

        RD_RESP: begin
          if (!w_dec_err) begin
            w_rvalid         = m_axil_if.rvalid;
            w_rdata          = m_axil_if.rdata;
            w_rresp          = m_axil_if.rresp;
            m_axil_if.rready = w_g_rready;
          end else begin
            w_rvalid = 1'b1;
            w_rresp  = 2'b11;
          end
          if (w_rvalid && w_g_rready) begin
            w_resp_done  = 1'b1;
            w_state_next = IDLE;
          end
        end

        default: w_state_next = IDLE;
      endcase
    end

    // Responses reach only the granted port; the other one sees zeros.
    s0_axil_if.awready = r_grant[1] ? 1'b0  : w_awready;
    s0_axil_if.wready  = r_grant[1] ? 1'b0  : w_wready;
    s0_axil_if.bvalid  = r_grant[1] ? 1'b0  : w_bvalid;
    s0_axil_if.bresp   = r_grant[1] ? 2'b00 : w_bresp;
    s0_axil_if.arready = r_grant[1] ? 1'b0  : w_arready;
    s0_axil_if.rvalid  = r_grant[1] ? 1'b0  : w_rvalid;
    s0_axil_if.rdata   = r_grant[1] ? '0    : w_rdata;
    s0_axil_if.rresp   = r_grant[1] ? 2'b00 : w_rresp;
    s1_axil_if.awready = r_grant[1] ? w_awready : 1'b0;
    s1_axil_if.wready  = r_grant[1] ? w_wready  : 1'b0;
    s1_axil_if.bvalid  = r_grant[1] ? w_bvalid  : 1'b0;
    s1_axil_if.bresp   = r_grant[1] ? w_bresp   : 2'b00;
    s1_axil_if.arready = r_grant[1] ? w_arready : 1'b0;
    s1_axil_if.rvalid  = r_grant[1] ? w_rvalid  : 1'b0;
    s1_axil_if.rdata   = r_grant[1] ? w_rdata   : '0;
    s1_axil_if.rresp   = r_grant[1] ? w_rresp   : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_pick_vld) begin
        r_grant <= w_pick;
      end
      // Done flags live only while collecting AW/W; cleared on exit.
      if (r_state == WR_ADDR_DATA && w_state_next == WR_ADDR_DATA) begin
        r_aw_done <= r_aw_done | w_aw_hs;
        r_w_done  <= r_w_done | w_w_hs;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_resp_done) begin
        r_ptr <= r_grant + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire
